// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative L1 data cache controller: write-through, no-write-allocate,
// burst line refill on load miss, first-invalid-then-round-robin replacement,
// single outstanding request and saturating hit/miss counters.
module set_assoc_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_load,
    input  logic              cpu_store,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL, S_WR_REQ, S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic              is_load;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [OFF_W-1:0]  beat;
    logic [WAY_W-1:0]  victim_q;

    logic [WAYS-1:0]   valid    [SETS];
    logic [WAY_W-1:0]  rr_ptr   [SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];

    logic              accept, hit, found, beat_in, last_beat;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign off       = addr_q[OFF_W-1:0];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign accept    = (state == S_IDLE) && (cpu_load ^ cpu_store);
    assign beat_in   = (state == S_REFILL) && mem_rvalid;
    assign last_beat = beat_in && (beat == LAST_BEAT);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Parallel tag compare across all ways of the latched set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && (tag_mem[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the set's round-robin pointer
    always_comb begin
        victim = rr_ptr[idx];
        found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid[idx][w]) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept) state_nxt = S_LOOKUP;
            S_LOOKUP:     state_nxt = !is_load ? S_WR_REQ : (hit ? S_RESP : S_REFILL_REQ);
            S_REFILL_REQ: if (mem_gnt) state_nxt = S_REFILL;
            S_REFILL:     if (last_beat) state_nxt = S_RESP;
            S_WR_REQ:     if (mem_gnt) state_nxt = S_RESP;
            S_RESP:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        cpu_ready = (state == S_IDLE);
        cpu_done  = (state == S_RESP);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_REFILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
            S_WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // Control state: valid bits, replacement pointers, beat counter, counters, load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load   <= 1'b0;
            beat      <= '0;
            victim_q  <= '0;
            cpu_rdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            if (accept) is_load <= cpu_load;
            if (state == S_LOOKUP) begin
                victim_q <= victim;
                if (hit) begin
                    hit_cnt <= sat_inc(hit_cnt);
                    if (is_load) cpu_rdata <= data_mem[hit_way][idx][off];
                end else begin
                    miss_cnt <= sat_inc(miss_cnt);
                end
            end
            if (state == S_REFILL_REQ) beat <= '0;
            if (beat_in) begin
                beat <= beat + OFF_W'(1);
                if (beat == off) cpu_rdata <= mem_rdata;
            end
            if (last_beat) begin
                valid[idx][victim_q] <= 1'b1;
                rr_ptr[idx] <= (rr_ptr[idx] == LAST_WAY) ? '0 : rr_ptr[idx] + WAY_W'(1);
            end
        end
    end

    // Request latch and tag/data arrays (not cleared by reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
        if ((state == S_LOOKUP) && hit && !is_load) data_mem[hit_way][idx][off] <= wdata_q;
        if (beat_in) data_mem[victim_q][idx][beat] <= mem_rdata;
        if (last_beat) tag_mem[victim_q][idx] <= tag;
    end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench for set_assoc_cache_ctrl: table of load/store vectors with
// expected hit/miss and load data, a responding memory model, a done scoreboard,
// and hand-written sequences for illegal requests and reset during refill.
module tb_set_assoc_cache_ctrl;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_load, cpu_store;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready, cpu_done;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(4), .SETS(16), .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        bit          rst;
        bit          store;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hit;
        logic [31:0] rdata;
        int          dly;
        bit          gap;
    } vec_t;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    exp_t        sb[$];
    exp_t        popped;
    vec_t        tbl[19];

    // memory model state
    logic [31:0] mem_store [logic [31:0]];
    int          gnt_delay = 0;
    bit          gap_mode = 0;
    bit          gap_done = 0;
    int          wait_cnt = 0;
    int          beats_left = 0;
    int          beat_no = 0;
    int          cur_beat = -1;
    int          req_cnt = 0;
    logic [31:0] rbase = '0;
    logic        last_we = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a + 32'h20;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: grants after gnt_delay cycles, streams refill beats
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            cur_beat = -1;
            if (!rst_n) begin
                wait_cnt = 0;
                beats_left = 0;
            end else if (beats_left > 0) begin
                if (gap_mode && beat_no == 2 && !gap_done) begin
                    gap_done = 1'b1;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = model_rd(rbase + 32'(beat_no));
                    cur_beat   = beat_no;
                    beat_no++;
                    beats_left--;
                end
            end else if (mem_req) begin
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    wait_cnt = 0;
                    req_cnt++;
                    last_we = mem_we;
                    last_addr = mem_addr;
                    last_wdata = mem_wdata;
                    if (mem_we) begin
                        mem_store[mem_addr] = mem_wdata;
                    end else begin
                        rbase = mem_addr;
                        beat_no = 0;
                        gap_done = 1'b0;
                        beats_left = gap_mode ? LINE_WORDS + 1 : LINE_WORDS;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Completion monitor: every cpu_done pops the scoreboard and checks load data
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cpu_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    popped = sb.pop_front();
                    if (popped.is_load) check("load_rdata", cpu_rdata, popped.rdata);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        cpu_load = 1'b0;
        cpu_store = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_cpu_done",  32'(cpu_done),  32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_addr",  mem_addr,       32'd0);
        check("rst_mem_wdata", mem_wdata,      32'd0);
        check("rst_cpu_rdata", cpu_rdata,      32'd0);
        check("rst_hit_cnt",   hit_cnt,        32'd0);
        check("rst_miss_cnt",  miss_cnt,       32'd0);
        rst_n = 1'b1;
        exp_hits = 0;
        exp_misses = 0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic do_req(input vec_t v);
        int lat;
        int req_before;
        logic [31:0] line_base;
        line_base = {v.addr[31:3], 3'b000};
        lat = 0;
        while (!cpu_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("ready_before_req", 32'(cpu_ready), 32'd1);
        gnt_delay = v.dly;
        gap_mode = v.gap;
        req_before = req_cnt;
        cpu_load = !v.store;
        cpu_store = v.store;
        cpu_addr = v.addr;
        cpu_wdata = v.wdata;
        sb.push_back('{is_load: !v.store, rdata: v.rdata});
        @(negedge clk);
        cpu_load = 1'b0;
        cpu_store = 1'b0;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
        lat = 1;
        while (!cpu_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!cpu_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout addr=0x%0h actual=no_done expected=done", v.addr);
            return;
        end
        if (v.hit) exp_hits++;
        else exp_misses++;
        if (!v.store && v.hit) begin
            check("hit_latency", 32'(lat), 32'd2);
            check("hit_no_memreq", 32'(req_cnt), 32'(req_before));
        end else begin
            check("memreq_count", 32'(req_cnt), 32'(req_before + 1));
            check("mem_we", 32'(last_we), 32'(v.store));
            check("mem_addr", last_addr, v.store ? v.addr : line_base);
            if (v.store) check("mem_wdata", last_wdata, v.wdata);
        end
        check("hit_cnt", hit_cnt, 32'(exp_hits));
        check("miss_cnt", miss_cnt, 32'(exp_misses));
        @(negedge clk);
        check("done_one_cycle", 32'(cpu_done), 32'd0);
        check("ready_after_done", 32'(cpu_ready), 32'd1);
        if (!v.store) check("rdata_hold", cpu_rdata, v.rdata);
    endtask

    initial begin
        int lat;
        int req_before;
        bit fired;
        cpu_load = 1'b0;
        cpu_store = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;

        //          rst store addr       wdata       hit rdata       dly gap
        tbl[0]  = '{1, 0, 32'h0000_0080, 32'h0,      0, 32'h0000_00A0, 0, 0};
        tbl[1]  = '{0, 0, 32'h0000_0085, 32'h0,      1, 32'h0000_00A5, 0, 0};
        tbl[2]  = '{0, 1, 32'h0000_0083, 32'hDEAD,   1, 32'h0,         2, 0};
        tbl[3]  = '{0, 0, 32'h0000_0083, 32'h0,      1, 32'h0000_DEAD, 0, 0};
        tbl[4]  = '{0, 1, 32'h0000_1000, 32'hBEEF,   0, 32'h0,         0, 0};
        tbl[5]  = '{0, 0, 32'h0000_1000, 32'h0,      0, 32'h0000_BEEF, 1, 1};
        tbl[6]  = '{0, 0, 32'h0000_1007, 32'h0,      1, 32'h0000_1027, 0, 0};
        tbl[7]  = '{1, 0, 32'h0000_0000, 32'h0,      0, 32'h0000_0020, 0, 0};
        tbl[8]  = '{0, 0, 32'h0000_0080, 32'h0,      0, 32'h0000_00A0, 0, 0};
        tbl[9]  = '{0, 0, 32'h0000_0101, 32'h0,      0, 32'h0000_0121, 3, 0};
        tbl[10] = '{0, 0, 32'h0000_0187, 32'h0,      0, 32'h0000_01A7, 0, 1};
        tbl[11] = '{0, 0, 32'h0000_0200, 32'h0,      0, 32'h0000_0220, 0, 0};
        tbl[12] = '{0, 0, 32'h0000_0005, 32'h0,      0, 32'h0000_0025, 0, 0};
        tbl[13] = '{0, 0, 32'h0000_0102, 32'h0,      1, 32'h0000_0122, 0, 0};
        tbl[14] = '{0, 0, 32'h0000_0183, 32'h0,      1, 32'h0000_01A3, 0, 0};
        tbl[15] = '{0, 0, 32'h0000_0206, 32'h0,      1, 32'h0000_0226, 0, 0};
        tbl[16] = '{0, 0, 32'h0000_0083, 32'h0,      0, 32'h0000_DEAD, 0, 0};
        tbl[17] = '{0, 1, 32'h0000_0003, 32'h1234,   1, 32'h0,         0, 0};
        tbl[18] = '{0, 0, 32'h0000_0003, 32'h0,      1, 32'h0000_1234, 0, 0};

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].rst) do_reset();
            do_req(tbl[i]);
        end

        // Both load and store asserted: no request accepted
        req_before = req_cnt;
        cpu_load = 1'b1;
        cpu_store = 1'b1;
        cpu_addr = 32'h80;
        @(negedge clk);
        cpu_load = 1'b0;
        cpu_store = 1'b0;
        check("both_ready", 32'(cpu_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("both_no_memreq", 32'(req_cnt), 32'(req_before));
        check("both_hit_cnt", hit_cnt, 32'(exp_hits));
        check("both_miss_cnt", miss_cnt, 32'(exp_misses));

        // Reset asserted while refill beat 3 is on the bus
        do_reset();
        gnt_delay = 0;
        gap_mode = 1'b0;
        cpu_load = 1'b1;
        cpu_addr = 32'h80;
        sb.push_back('{is_load: 1'b1, rdata: 32'hA0});
        @(negedge clk);
        cpu_load = 1'b0;
        fired = 1'b0;
        lat = 0;
        while (!fired && lat < 100) begin
            @(negedge clk);
            #1;
            if (mem_rvalid && cur_beat == 3) begin
                rst_n = 1'b0;
                fired = 1'b1;
            end
            lat++;
        end
        check("abort_beat3_seen", 32'(fired), 32'd1);
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_cpu_done", 32'(cpu_done), 32'd0);
        check("abort_ready", 32'(cpu_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(sb.size()), 32'd1);
        check("abort_miss_cnt", miss_cnt, 32'd0);
        sb.delete();
        exp_hits = 0;
        exp_misses = 0;
        do_req('{0, 0, 32'h80, 32'h0, 0, 32'hA0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
